// File: rtl/pwm_regs_pkg.sv
// pwm_regs_pkg: register map constants and CTRL layout shared by the PWM register bank
package pwm_regs_pkg;
  localparam int unsigned ADDR_CTRL = 0;
  localparam int unsigned ADDR_PRESCALE = 1;
  localparam int unsigned ADDR_DUTY_LO = 2;
  localparam int unsigned ADDR_DUTY_HI = 3;
  localparam int CTRL_EN = 0;
  localparam int CTRL_INV = 1;
  typedef struct packed {
    logic inv;
    logic en;
  } ctrl_t;
endpackage

// File: rtl/pwm_regbank_if.sv
// pwm_regbank_if: single-cycle register write strobe bus from the I2C slave
interface pwm_regbank_if #(parameter int REGBITS = 2) ();
  logic [REGBITS-1:0] regAddr;
  logic [7:0] regData;
  logic regDataValid;
  modport master(output regAddr, regData, regDataValid);
  modport slave(input regAddr, regData, regDataValid);
endinterface

// File: rtl/pwm_prescaler.sv
// pwm_prescaler: 8-bit divider, tick when the count reaches div, cleared when idle or on clr
module pwm_prescaler (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clr,
  input  logic [7:0] div,
  output logic       tick
);
  logic [7:0] cnt;
  assign tick = en && cnt == div;
  // Count 0..div, restarting after each tick; held at 0 while disabled or cleared
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (!en || clr || tick) ? '0 : cnt + 8'd1;
endmodule

// File: rtl/pwm_regbank.sv
// pwm_regbank: PWM control registers with double-buffered duty and glitch-free PWM output
module pwm_regbank
  import pwm_regs_pkg::*;
#(
  parameter int REGBITS = 2,
  parameter int PWMBITS = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  pwm_regbank_if.slave       bus,
  output logic               pwm_out,
  output logic               cycle_start,
  output logic [PWMBITS-1:0] duty_active,
  output logic               update_pending
);
  localparam logic [PWMBITS-1:0] CNT_MAX = '1;
  ctrl_t ctrl;
  logic [7:0] prescale, lo_stage;
  logic [PWMBITS-1:0] pending, cnt, wr_duty;
  logic [REGBITS-1:0] addr;
  logic pending_vld, tick, wr_ctrl, wr_presc, wr_lo, wr_hi, start, stop, boundary, load;
  assign addr = bus.regAddr;
  assign update_pending = pending_vld;
  // Write decode and period events; a stop write suppresses a coincident boundary
  always_comb begin
    wr_ctrl = bus.regDataValid && addr == REGBITS'(ADDR_CTRL);
    wr_presc = bus.regDataValid && addr == REGBITS'(ADDR_PRESCALE);
    wr_lo = bus.regDataValid && addr == REGBITS'(ADDR_DUTY_LO);
    wr_hi = bus.regDataValid && addr == REGBITS'(ADDR_DUTY_HI);
    wr_duty = {bus.regData[PWMBITS-9:0], lo_stage};
    start = wr_ctrl && bus.regData[CTRL_EN] && !ctrl.en;
    stop = wr_ctrl && !bus.regData[CTRL_EN];
    boundary = tick && cnt == CNT_MAX && !stop;
    load = (boundary || start) && pending_vld;
  end
  pwm_prescaler u_presc (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (ctrl.en),
    .clr  (wr_presc || stop),
    .div  (prescale),
    .tick (tick)
  );
  // Control, prescale and low-byte staging registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ctrl <= '0;
      prescale <= '0;
      lo_stage <= '0;
    end else begin
      if (wr_ctrl) ctrl <= '{inv: bus.regData[CTRL_INV], en: bus.regData[CTRL_EN]};
      if (wr_presc) prescale <= bus.regData;
      if (wr_lo) lo_stage <= bus.regData;
    end
  // Duty double buffer: a new value waits for a boundary while running, loads directly when idle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pending <= '0;
      pending_vld <= 1'b0;
      duty_active <= '0;
    end else begin
      if (wr_hi) pending <= wr_duty;
      pending_vld <= wr_hi ? ctrl.en : pending_vld && !load;
      duty_active <= (wr_hi && !ctrl.en) ? wr_duty : load ? pending : duty_active;
    end
  // Period counter, boundary pulse and registered compare output
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      cycle_start <= 1'b0;
      pwm_out <= 1'b0;
    end else begin
      cnt <= (!ctrl.en || stop) ? '0 : tick ? cnt + PWMBITS'(1) : cnt;
      cycle_start <= boundary || start;
      pwm_out <= (ctrl.en && cnt < duty_active) ^ ctrl.inv;
    end
endmodule

// File: tb/tb_pwm_regbank.sv
// tb_pwm_regbank: table-driven and scoreboard checks of the PWM register bank
module tb_pwm_regbank;
  import pwm_regs_pkg::*;
  localparam int REGBITS = 2;
  localparam int PWMBITS = 9;
  localparam int P = 512;
  typedef struct {
    int presc;
    int duty;
    bit inv;
    int exp_high;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pwm_out, cycle_start, update_pending;
  logic [PWMBITS-1:0] duty_active;
  int total = 0;
  int bad = 0;
  int exp_q[$];
  vec_t vecs[8];
  pwm_regbank_if #(.REGBITS(REGBITS)) bus ();
  pwm_regbank #(.REGBITS(REGBITS), .PWMBITS(PWMBITS)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .pwm_out(pwm_out),
    .cycle_start(cycle_start),
    .duty_active(duty_active),
    .update_pending(update_pending)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask
  task automatic drive(input int a, input int d, input logic v);
    bus.regAddr = REGBITS'(a);
    bus.regData = 8'(d);
    bus.regDataValid = v;
  endtask
  task automatic wr(input int a, input int d);
    @(negedge clk);
    drive(a, d, 1'b1);
    @(negedge clk);
    drive(0, 0, 1'b0);
  endtask
  task automatic setup(input int presc, input int duty, input int ctrl_val);
    wr(ADDR_CTRL, 0);
    wr(ADDR_PRESCALE, presc);
    wr(ADDR_DUTY_LO, duty & 255);
    wr(ADDR_DUTY_HI, duty >> 8);
    wr(ADDR_CTRL, ctrl_val);
  endtask
  task automatic wait_cs(input int budget, input string name);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (cycle_start) break;
    end
    check(name, cycle_start, 1);
  endtask
  task automatic collect(input int periods, input bit aligned, input int budget, input int exp_len);
    int acc, len, seen, exp;
    acc = 0;
    len = 0;
    seen = aligned ? 1 : 0;
    for (int k = 0; k < budget && seen <= periods; k++) begin
      @(negedge clk);
      acc += int'(pwm_out);
      len++;
      if (cycle_start) begin
        if (seen > 0) begin
          exp = exp_q.size() > 0 ? exp_q.pop_front() : -1;
          check("period_high", acc, exp);
          check("period_len", len, exp_len);
        end
        seen++;
        acc = 0;
        len = 0;
      end
    end
    check("collect_periods", seen, periods + 1);
    exp_q.delete();
  endtask
  initial begin
    int acc, pulses, k;
    vecs[0] = '{0, 128, 1'b0, 128};
    vecs[1] = '{0, 256, 1'b0, 256};
    vecs[2] = '{3, 1, 1'b0, 4};
    vecs[3] = '{0, 0, 1'b0, 0};
    vecs[4] = '{0, 511, 1'b0, 511};
    vecs[5] = '{0, 0, 1'b1, 512};
    vecs[6] = '{1, 100, 1'b1, 824};
    vecs[7] = '{0, 300, 1'b0, 300};
    drive(0, 0, 1'b0);
    repeat (3) @(negedge clk);
    check("rst_pwm", pwm_out, 0);
    check("rst_duty", duty_active, 0);
    check("rst_pending", update_pending, 0);
    check("rst_cs", cycle_start, 0);
    rst_n = 1'b1;
    acc = 0;
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      acc += int'(pwm_out);
      pulses += int'(cycle_start);
    end
    check("idle_pwm_high", acc, 0);
    check("idle_cs_pulses", pulses, 0);
    check("idle_pending", update_pending, 0);
    for (int i = 0; i < 8; i++) begin
      wr(ADDR_CTRL, 0);
      wr(ADDR_PRESCALE, vecs[i].presc);
      wr(ADDR_DUTY_LO, vecs[i].duty & 255);
      wr(ADDR_DUTY_HI, vecs[i].duty >> 8);
      check($sformatf("v%0d_duty_direct", i), duty_active, vecs[i].duty);
      check($sformatf("v%0d_pending", i), update_pending, 0);
      wr(ADDR_CTRL, vecs[i].inv ? 3 : 1);
      exp_q.push_back(vecs[i].exp_high);
      exp_q.push_back(vecs[i].exp_high);
      collect(2, 1'b0, (vecs[i].presc + 1) * P * 4 + 50, (vecs[i].presc + 1) * P);
    end
    setup(0, 128, 1);
    wait_cs(P + 50, "b_sync");
    acc = 0;
    for (int i = 1; i <= P; i++) begin
      @(negedge clk);
      acc += int'(pwm_out);
      if (i == 200) begin
        check("b_pending_mid", update_pending, 1);
        check("b_duty_mid", duty_active, 128);
      end
      if (i == P - 1) check("b_pending_late", update_pending, 1);
      if (i == 100) drive(ADDR_DUTY_LO, 0, 1'b1);
      if (i == 101) drive(ADDR_DUTY_HI, 1, 1'b1);
      if (i == 102) drive(0, 0, 1'b0);
    end
    check("b_boundary_cs", cycle_start, 1);
    check("b_pending_clr", update_pending, 0);
    check("b_duty_loaded", duty_active, 256);
    check("b_old_period_high", acc, 128);
    exp_q.push_back(256);
    collect(1, 1'b1, P + 50, P);
    wait_cs(P + 50, "c_sync");
    for (int i = 1; i <= P; i++) begin
      @(negedge clk);
      if (i == 20) check("c_pending_set", update_pending, 1);
      if (i == P) begin
        check("c_boundary_cs", cycle_start, 1);
        check("c_duty_old_pending", duty_active, 64);
        check("c_pending_new", update_pending, 1);
      end
      if (i == 10) drive(ADDR_DUTY_LO, 8'h40, 1'b1);
      if (i == 11) drive(ADDR_DUTY_HI, 0, 1'b1);
      if (i == 12 || i == P) drive(0, 0, 1'b0);
      if (i == P - 2) drive(ADDR_DUTY_LO, 8'h20, 1'b1);
      if (i == P - 1) drive(ADDR_DUTY_HI, 1, 1'b1);
    end
    exp_q.push_back(64);
    exp_q.push_back(288);
    collect(2, 1'b1, 3 * P, P);
    check("c_duty_final", duty_active, 288);
    check("c_pending_final", update_pending, 0);
    setup(0, 0, 3);
    repeat (5) @(negedge clk);
    acc = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      acc += int'(pwm_out);
    end
    check("d_inv_high", acc, 200);
    wr(ADDR_CTRL, 2);
    acc = 0;
    pulses = 0;
    for (int i = 0; i < 2 * P; i++) begin
      @(negedge clk);
      acc += int'(pwm_out);
      pulses += int'(cycle_start);
    end
    check("d_disabled_high", acc, 2 * P);
    check("d_disabled_cs", pulses, 0);
    wr(ADDR_CTRL, 3);
    check("d_restart_cs", cycle_start, 1);
    for (k = 1; k <= P + 10; k++) begin
      @(negedge clk);
      if (cycle_start) break;
    end
    check("d_restart_period", k, P);
    setup(0, 300, 1);
    wait_cs(P + 50, "e_sync");
    repeat (40) @(negedge clk);
    wr(ADDR_DUTY_HI, 0);
    check("e_pending_set", update_pending, 1);
    check("e_pwm_high", pwm_out, 1);
    #2 rst_n = 1'b0;
    #1;
    check("e_rst_pwm", pwm_out, 0);
    check("e_rst_duty", duty_active, 0);
    check("e_rst_pending", update_pending, 0);
    check("e_rst_cs", cycle_start, 0);
    @(negedge clk);
    rst_n = 1'b1;
    acc = 0;
    pulses = 0;
    for (int i = 0; i < 2 * P; i++) begin
      @(negedge clk);
      acc += int'(pwm_out);
      pulses += int'(cycle_start);
    end
    check("e_after_rst_high", acc, 0);
    check("e_after_rst_cs", pulses, 0);
    check("e_after_rst_duty", duty_active, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
